serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
// - Bit-serial subtractor: consumes operand bit pairs LSB-first, computes A-B-BI one bit per cycle
//   through a full-subtractor cell, keeps the running borrow in a flop.
// - Companion to the adder logic cell: that cell carries a sum forward; this block carries a borrow.
// - Sits between serial operand streams and parallel result consumers; valid/ready on both sides.
// PARAMETERS
// - WIDTH  4  operand/result width in bits (>=2); also the bit count per operation
// PORTS
// - QCK        in   1      clock, rising edge
// - QRT        in   1      reset, asynchronous, active-low
// - START      in   1      begin operation; sampled only in IDLE
// - BI         in   1      initial borrow, captured with START
// - IN_VALID   in   1      A/B bit pair valid
// - IN_READY   out  1      block accepts a bit pair this cycle
// - A          in   1      minuend bit
// - B          in   1      subtrahend bit
// - DZ         out  1      registered difference bit of the last accepted pair
// - DZ_VALID   out  1      one-cycle pulse: DZ updated
// - DIFF       out  WIDTH  parallel difference, bit 0 = LSB
// - BO         out  1      final borrow-out
// - OUT_VALID  out  1      DIFF/BO valid
// - OUT_READY  in   1      consumer takes the result
// BEHAVIOUR
// - Reset (QRT=0, any time, async): state=IDLE, borrow=0, count=0.
//   DIFF=0, DZ=0, DZ_VALID=0, BO=0, OUT_VALID=0, IN_READY=0.
// - Reset mid-operation discards the partial result; no DZ_VALID or OUT_VALID follows.
// - States: IDLE, RUN, HOLD.
//   IDLE -> RUN when START=1; borrow<=BI, count<=0, DIFF<=0.
//   RUN: IN_READY=1. Accept = IN_VALID & IN_READY.
//     On accept, full-subtractor cell:
//       d  = A^B^borrow
//       bn = (~A&B) | (~(A^B)&borrow)
//     Registered updates: borrow<=bn, DZ<=d, DZ_VALID<=1 (else 0).
//     DIFF <= {d, DIFF[WIDTH-1:1]} (right shift, LSB lands in bit 0 after WIDTH accepts).
//     count increments.
//   RUN -> HOLD on the accept with count==WIDTH-1; same edge: BO<=bn, OUT_VALID<=1.
//   HOLD: IN_READY=0; DIFF, BO, OUT_VALID stable until OUT_READY=1.
//   HOLD -> IDLE on OUT_READY=1: OUT_VALID<=0. DIFF/BO retain their values until the next START.
// - Latency: result valid the cycle after the WIDTH-th accept. Each bit costs 1 cycle, no stall overhead.
// - IN_VALID=0 in RUN: no state change (stall, borrow held).
// - START outside IDLE is ignored; BI is ignored except with START in IDLE.
// - START and IN_VALID in the same IDLE cycle: the pair is not consumed (IN_READY=0 in IDLE).
// - OUT_READY outside HOLD is ignored; no back-to-back START is taken in the HOLD->IDLE cycle.
// - Arithmetic is modulo 2^WIDTH.
//   BO=1 iff A < B+BI as unsigned values, i.e. {BO,DIFF} = A - B - BI in two's complement.
// - count is $clog2(WIDTH) bits and never wraps within an operation; it clears on START.
// STRUCTURE
// - Shared package: state encoding (IDLE=2'd0, RUN=2'd1, HOLD=2'd2).
// - Sub-module full_subtractor (A, B, BI -> D, BO): combinational, sibling to full_adder.
// - Top: FSM, borrow flop, counter, DIFF shift register, output registers.
// TESTING
// - WIDTH=4, BI=0, A=0101, B=0011 LSB-first, IN_VALID held high
//   -> DZ sequence 0,1,0,0; DIFF=0010, BO=0; OUT_VALID 1 cycle after 4th accept.
// - A=0011, B=0101, BI=0 -> DIFF=1110, BO=1.
// - A=0000, B=0000, BI=1 -> DIFF=1111, BO=1 (borrow chain through all bits).
// - IN_VALID low for 3 cycles between bit 1 and bit 2 of 5-3
//   -> same DIFF=0010, BO=0; count/borrow frozen while stalled; no DZ_VALID during the stall.
// - OUT_READY low for 5 cycles in HOLD -> DIFF/BO/OUT_VALID stable; START and IN_VALID ignored.
//   After OUT_READY=1 -> IDLE next cycle.
// - QRT asserted after 2 accepts, then released, then a new 5-3 run
//   -> all outputs 0 during reset; no OUT_VALID from the aborted run; new run gives DIFF=0010.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: D = A - B - BI, borrow-out in BO.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bi_i,
  output logic d_o,
  output logic bo_o
);

  assign d_o  = a_i ^ b_i ^ bi_i;
  assign bo_o = (~a_i & b_i) | (~(a_i ^ b_i) & bi_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: LSB-first operand pairs, running borrow in a flop,
// parallel difference and final borrow presented with valid/ready.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             QCK,
  input  logic             QRT,
  input  logic             START,
  input  logic             BI,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             A,
  input  logic             B,
  output logic             DZ,
  output logic             DZ_VALID,
  output logic [WIDTH-1:0] DIFF,
  output logic             BO,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               dz_q, dz_d;
  logic               dz_valid_q, dz_valid_d;
  logic               bo_q, bo_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready;
  logic               cell_d, cell_bo;

  full_subtractor u_cell (
    .a_i  (A),
    .b_i  (B),
    .bi_i (borrow_q),
    .d_o  (cell_d),
    .bo_o (cell_bo)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d     = state_q;
    borrow_d    = borrow_q;
    count_d     = count_q;
    diff_d      = diff_q;
    dz_d        = dz_q;
    dz_valid_d  = 1'b0;
    bo_d        = bo_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d  = RUN;
          borrow_d = BI;
          count_d  = '0;
          diff_d   = '0;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (IN_VALID) begin
          borrow_d   = cell_bo;
          dz_d       = cell_d;
          dz_valid_d = 1'b1;
          diff_d     = {cell_d, diff_q[WIDTH-1:1]};
          // The final accept leaves count at WIDTH-1 so it never wraps.
          if (count_q == LAST) begin
            state_d     = HOLD;
            bo_d        = cell_bo;
            out_valid_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (OUT_READY) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge QCK or negedge QRT) begin
    if (!QRT) begin
      state_q     <= IDLE;
      borrow_q    <= 1'b0;
      count_q     <= '0;
      diff_q      <= '0;
      dz_q        <= 1'b0;
      dz_valid_q  <= 1'b0;
      bo_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      borrow_q    <= borrow_d;
      count_q     <= count_d;
      diff_q      <= diff_d;
      dz_q        <= dz_d;
      dz_valid_q  <= dz_valid_d;
      bo_q        <= bo_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY  = in_ready;
  assign DZ        = dz_q;
  assign DZ_VALID  = dz_valid_q;
  assign DIFF      = diff_q;
  assign BO        = bo_q;
  assign OUT_VALID = out_valid_q;

endmodule
